router_fsm: RTL
===============

// Module: router_fsm
// PURPOSE
//  Packet-sequencing controller for the 1x3 router input side. Decodes the header address,
//  waits for the destination FIFO (fifo_3 instance 0/1/2) to drain, then sequences header,
//  payload, after-full and parity loads into the register/FIFO datapath.
//  Drives FIFO write enable and lfd_state, and tells the sender when to stall (busy).
// PARAMETERS
//  CNT_W  8  width of optional completed-packet counter (ROUTER_FSM_PKT_CNT_EN only)
// PORTS
//  clk            in   1  system clock, all logic on rising edge
//  resetn         in   1  synchronous active-low reset
//  pkt_valid      in   1  sender: header/payload byte valid; deasserts on parity byte
//  data_in        in   2  header bits [1:0] = destination address (3 = invalid)
//  parity_done    in   1  register block: parity byte captured
//  low_pkt_valid  in   1  register block: pkt_valid fell while FIFO was full
//  fifo_full      in   1  selected destination FIFO full
//  fifo_empty_0   in   1  FIFO 0 empty  (likewise fifo_empty_1, fifo_empty_2)
//  soft_reset_0   in   1  FIFO 0 read-timeout soft reset (likewise soft_reset_1, soft_reset_2)
//  detect_add     out  1  state == DECODE_ADDRESS
//  lfd_state      out  1  state == LOAD_FIRST_DATA (header write to FIFO)
//  ld_state       out  1  state == LOAD_DATA
//  laf_state      out  1  state == LOAD_AFTER_FULL
//  full_state     out  1  state == FIFO_FULL_STATE
//  write_enb_reg  out  1  LOAD_DATA | LOAD_PARITY | LOAD_AFTER_FULL
//  rst_int_reg    out  1  state == CHECK_PARITY_ERROR
//  busy           out  1  1 in every state except DECODE_ADDRESS and LOAD_DATA
//  dest_addr      out  2  latched destination of current packet
//  pkt_cnt        out  CNT_W  completed packets (only with ROUTER_FSM_PKT_CNT_EN)
// BEHAVIOUR
//  - Moore FSM, 8 states, one registered state vector; outputs decoded from state only.
//  - Reset (resetn=0 at edge): state=DECODE_ADDRESS, dest_addr=0, pkt_cnt=0 ->
//    detect_add=1, all other outputs 0. resetn has priority over everything.
//  - dest_addr loads data_in in DECODE_ADDRESS when pkt_valid=1 and data_in!=3; else holds.
//  - Soft reset: if soft_reset_<dest_addr>=1 in any state except DECODE_ADDRESS, next
//    state=DECODE_ADDRESS; overrides all transitions below. Other FIFOs' soft resets ignored.
//  - DECODE_ADDRESS: pkt_valid & addr!=3 & fifo_empty_<addr> -> LOAD_FIRST_DATA;
//    pkt_valid & addr!=3 & !fifo_empty_<addr> -> WAIT_TILL_EMPTY; else stay (addr 3 dropped).
//  - LOAD_FIRST_DATA -> LOAD_DATA unconditionally (exactly one cycle, header byte).
//  - LOAD_DATA: fifo_full -> FIFO_FULL_STATE; else !pkt_valid -> LOAD_PARITY; else stay.
//    fifo_full has priority when both occur in the same cycle.
//  - FIFO_FULL_STATE: !fifo_full -> LOAD_AFTER_FULL; else stay.
//  - LOAD_AFTER_FULL: parity_done -> DECODE_ADDRESS; else low_pkt_valid -> LOAD_PARITY;
//    else -> LOAD_DATA.
//  - LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
//  - CHECK_PARITY_ERROR: fifo_full -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
//  - WAIT_TILL_EMPTY: fifo_empty_<dest_addr> -> LOAD_FIRST_DATA; else stay.
//  - Latency: header seen in DECODE with empty FIFO -> lfd_state=1 next cycle, first
//    payload write (write_enb_reg) the cycle after. busy never glitches (registered state).
//  - Unused state encodings recover to DECODE_ADDRESS on the next clock.
// CONFIGURATION
//  ROUTER_FSM_PKT_CNT_EN defined: pkt_cnt port present; increments by 1 on every entry to
//    CHECK_PARITY_ERROR, wraps 2^CNT_W-1 -> 0; cleared by resetn only (not soft reset).
//  Not defined: pkt_cnt port and counter absent; all other behaviour identical.
// TESTING
//  1 resetn=0 one edge, pkt_valid=1 -> detect_add=1, busy=0, write_enb_reg=0, state DECODE.
//  2 header 8'h39 (len 14, addr 1), fifo_empty_1=1, 14 payload, pkt_valid drop -> states
//    DECODE,LFD,LD x14,LOAD_PARITY,CHECK_PARITY; write_enb_reg high 15 cycles; pkt_cnt=1.
//  3 addr 2 with fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY, busy=1 for 5 cycles;
//    fifo_empty_2=1 -> LOAD_FIRST_DATA next cycle, dest_addr=2.
//  4 fifo_full=1 in LOAD_DATA for 3 cycles -> full_state=1, busy=1; release with
//    low_pkt_valid=1 -> LOAD_AFTER_FULL then LOAD_PARITY; with parity_done=1 -> DECODE.
//  5 soft_reset_1=1 mid-payload of addr-1 packet -> DECODE next cycle; soft_reset_0=1
//    during same packet -> no effect.
//  6 header addr 3 with pkt_valid=1 -> stays DECODE, dest_addr unchanged; with PKT_CNT_EN
//    and CNT_W=2, 4 packets -> pkt_cnt 1,2,3,0.

Source files
------------

// File: rtl/router_fsm.sv
// Packet-sequencing FSM for the 1x3 router input side: header decode, FIFO wait, load sequencing.
// Optional completed-packet counter (pkt_cnt port) is built when ROUTER_FSM_PKT_CNT_EN is defined.
module router_fsm #(
    parameter int CNT_W = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pkt_valid,
    input  logic [1:0]  data_in,
    input  logic        parity_done,
    input  logic        low_pkt_valid,
    input  logic        fifo_full,
    input  logic        fifo_empty_0,
    input  logic        fifo_empty_1,
    input  logic        fifo_empty_2,
    input  logic        soft_reset_0,
    input  logic        soft_reset_1,
    input  logic        soft_reset_2,
    output logic        detect_add,
    output logic        lfd_state,
    output logic        ld_state,
    output logic        laf_state,
    output logic        full_state,
    output logic        write_enb_reg,
    output logic        rst_int_reg,
    output logic        busy,
    output logic [1:0]  dest_addr,
    output logic [2:0]  o_dbg_state
`ifdef ROUTER_FSM_PKT_CNT_EN
    ,
    output logic [CNT_W-1:0] pkt_cnt
`endif
);

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        LOAD_AFTER_FULL    = 3'd3,
        FIFO_FULL_STATE    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } state_t;

    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("router_fsm: CNT_W must be at least 1");
    end

    state_t     r_state;
    state_t     w_next_state;
    logic [1:0] r_dest_addr;
    logic       w_hdr_ok;
    logic       w_hdr_empty;
    logic       w_dest_empty;
    logic       w_dest_soft_reset;

    // A header is accepted only for addresses 0..2; address 3 is silently dropped.
    assign w_hdr_ok = pkt_valid && (data_in != 2'd3);

    always_comb begin
        w_hdr_empty = 1'b0;
        case (data_in)
            2'd0:    w_hdr_empty = fifo_empty_0;
            2'd1:    w_hdr_empty = fifo_empty_1;
            2'd2:    w_hdr_empty = fifo_empty_2;
            default: w_hdr_empty = 1'b0;
        endcase
    end

    always_comb begin
        w_dest_empty      = 1'b0;
        w_dest_soft_reset = 1'b0;
        case (r_dest_addr)
            2'd0: begin
                w_dest_empty      = fifo_empty_0;
                w_dest_soft_reset = soft_reset_0;
            end
            2'd1: begin
                w_dest_empty      = fifo_empty_1;
                w_dest_soft_reset = soft_reset_1;
            end
            2'd2: begin
                w_dest_empty      = fifo_empty_2;
                w_dest_soft_reset = soft_reset_2;
            end
            default: begin
                w_dest_empty      = 1'b0;
                w_dest_soft_reset = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= DECODE_ADDRESS;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (r_state != DECODE_ADDRESS && w_dest_soft_reset) begin
            // A read-timeout on the active destination abandons the packet from any state.
            w_next_state = DECODE_ADDRESS;
        end else begin
            case (r_state)
                DECODE_ADDRESS: begin
                    if (w_hdr_ok) begin
                        w_next_state = w_hdr_empty ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
                end
                LOAD_FIRST_DATA: w_next_state = LOAD_DATA;
                LOAD_DATA: begin
                    if (fifo_full) begin
                        w_next_state = FIFO_FULL_STATE;
                    end else if (!pkt_valid) begin
                        w_next_state = LOAD_PARITY;
                    end
                end
                FIFO_FULL_STATE: begin
                    if (!fifo_full) begin
                        w_next_state = LOAD_AFTER_FULL;
                    end
                end
                LOAD_AFTER_FULL: begin
                    if (parity_done) begin
                        w_next_state = DECODE_ADDRESS;
                    end else if (low_pkt_valid) begin
                        w_next_state = LOAD_PARITY;
                    end else begin
                        w_next_state = LOAD_DATA;
                    end
                end
                LOAD_PARITY: w_next_state = CHECK_PARITY_ERROR;
                CHECK_PARITY_ERROR: begin
                    w_next_state = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
                end
                WAIT_TILL_EMPTY: begin
                    if (w_dest_empty) begin
                        w_next_state = LOAD_FIRST_DATA;
                    end
                end
                default: w_next_state = DECODE_ADDRESS;
            endcase
        end
    end

    always_comb begin
        detect_add    = (r_state == DECODE_ADDRESS);
        lfd_state     = (r_state == LOAD_FIRST_DATA);
        ld_state      = (r_state == LOAD_DATA);
        laf_state     = (r_state == LOAD_AFTER_FULL);
        full_state    = (r_state == FIFO_FULL_STATE);
        rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
        write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                        (r_state == LOAD_AFTER_FULL);
        busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
        dest_addr     = r_dest_addr;
        o_dbg_state   = r_state;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_dest_addr <= 2'd0;
        end else if (r_state == DECODE_ADDRESS && w_hdr_ok) begin
            r_dest_addr <= data_in;
        end
    end

`ifdef ROUTER_FSM_PKT_CNT_EN
    logic [CNT_W-1:0] r_pkt_cnt;

    // Counts entries to parity check; soft reset deliberately does not clear it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_pkt_cnt <= '0;
        end else if (w_next_state == CHECK_PARITY_ERROR && r_state != CHECK_PARITY_ERROR) begin
            r_pkt_cnt <= r_pkt_cnt + 1'b1;
        end
    end

    assign pkt_cnt = r_pkt_cnt;
`endif

endmodule
